ex_stage_mc: RTL and testbench
==============================

Name: ex_stage_mc

Overview:
- Parametrised execute-stage register block, DATA_W wide, successor to the single-cycle EX stage.
- Latches the external ALU result, the zf/nf/cf flags, the store-data path and the instruction into the EX/MEM pipeline register.
- Adds an iterative shift-add multiplier for MUL, driving a stall handshake back to ID/IF while it runs.
- Sits between the ID/EX registers plus external ALU and the MEM stage; gated by the global `exec` state as before.

Parameters:
- DATA_W, 16, width of the datapath (reg_A, reg_B, alu_res, reg_C, smdr, smdr1); legal values 8..32.
- MUL_OP, 5'b11110, opcode (ex_ir[15:11]) that selects the multi-cycle multiply.
- CNT_W, $clog2(DATA_W)+1, width of the iteration counter.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- state  in  1  CPU state; the block advances only when state == `exec
- ex_ir  in  16  instruction in EX; opcode is ex_ir[15:11], codes from define.v
- reg_A  in  DATA_W  operand A; multiplicand for MUL
- reg_B  in  DATA_W  operand B; multiplier for MUL
- smdr  in  DATA_W  store data for STORE
- alu_res  in  DATA_W  external ALU result for non-MUL ops
- alu_cf  in  1  external ALU carry out
- jump  in  1  branch taken; flush
- cf_fb  out  1  current cf, fed back as ALU carry-in
- stall  out  1  high while MUL is in progress; upstream holds ex_ir, reg_A and reg_B
- mem_ir  out  16  EX/MEM instruction register
- reg_C  out  DATA_W  EX/MEM result register
- zf, nf, cf  out  1 each  flag registers
- dw  out  1  data-memory write enable for MEM
- smdr1  out  DATA_W  registered store data
- reg_H  out  DATA_W  product high half (see Optional Feature)

Behaviour:
- Reset (reset==0 at a rising edge): all outputs are 0, FSM goes to IDLE, counter is 0, stall is 0. Applies mid-MUL; the partial product is discarded.
- state != `exec: all registers, the FSM and the counter hold. stall holds its value.
- FSM states are IDLE and BUSY. stall = (FSM == BUSY), decoded from the register.
- IDLE, exec, jump=1:
  - mem_ir<=0, dw<=0.
  - reg_C, flags and smdr1 hold.
- IDLE, exec, jump=0, opcode != MUL_OP: single-cycle, same as the existing EX stage.
  - mem_ir<=ex_ir, reg_C<=alu_res.
  - zf, nf and cf update only for LDIH, ADD, ADDI, ADDC, SUB, SUBI, SUBC, CMP: zf=(alu_res==0), nf=alu_res[DATA_W-1], cf=alu_cf.
  - STORE: dw<=1 and smdr1<=smdr. Any other opcode: dw<=0.
- IDLE, exec, jump=0, opcode == MUL_OP:
  - Go to BUSY. Load acc<=0, mcand<=reg_A, mplier<=reg_B, cnt<=DATA_W.
  - mem_ir<=0 (bubble), dw<=0.
- BUSY, each exec cycle:
  - If mplier[0], acc+=mcand (2*DATA_W-bit add).
  - mcand<<=1, mplier>>=1, cnt-=1. mem_ir<=0, dw<=0.
- BUSY with cnt==1 (final iteration): the partial update completes and the FSM returns to IDLE. On that same edge:
  - mem_ir<=ex_ir, reg_C<=product[DATA_W-1:0].
  - zf=(low half==0), nf=low[DATA_W-1].
  - cf=(high half != 0), i.e. unsigned overflow.
- MUL latency: DATA_W+1 exec cycles from MUL entering EX to mem_ir==MUL. stall is high for exactly DATA_W cycles.
- BUSY with jump=1: the abort has priority.
  - FSM->IDLE, mem_ir<=0, dw<=0.
  - Flags and reg_C are unchanged.
- Operands are unsigned. Products wrap modulo 2^DATA_W in reg_C.
- cf_fb = cf, combinational from the register.

Optional Feature:
- Macro: MUL_HI_EN.
- Defined: reg_H <= product[2*DATA_W-1:DATA_W] on MUL completion. reg_H holds otherwise and resets to 0.
- Not defined: reg_H is tied to 0 and no high-half register is built. The accumulator's high half is still kept for the cf overflow flag.

Test Plan:
- Reset, then ADD with alu_res=0x0000, alu_cf=1 -> mem_ir=ADD, reg_C=0, zf=1, nf=0, cf=1.
- STORE with smdr=0xBEEF -> dw=1, smdr1=0xBEEF. Next non-STORE -> dw=0 and smdr1 still 0xBEEF.
- MUL with DATA_W=16, A=0x0012, B=0x0034:
  - stall high for 16 cycles, mem_ir=0 during that time.
  - Then reg_C=0x03A8, zf=0, cf=0.
- MUL A=0xFFFF, B=0x0002 -> reg_C=0xFFFE, nf=1, cf=1. With MUL_HI_EN, reg_H=0x0001.
- Three interruption checks during a MUL:
  - jump at cycle 5 -> FSM IDLE, stall=0, mem_ir=0, flags unchanged.
  - reset low at cycle 7 -> all outputs 0.
  - state != `exec for 3 cycles mid-MUL -> counter frozen and total latency grows by 3.
- DATA_W=8 build, MUL 0x10*0x10 -> reg_C=0x00, zf=1, cf=1, stall high for 8 cycles.

Source files
------------

// File: rtl/ex_stage_mc.sv
// EX stage with EX/MEM pipeline register and an iterative shift-add multiplier for MUL.
// Optional macro MUL_HI_EN: registers the product high half on reg_H.
module ex_stage_mc #(
  parameter int          DATA_W = 16,
  parameter logic [4:0]  MUL_OP = 5'b11110,
  parameter int          CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              state,
  input  logic [15:0]       ex_ir,
  input  logic [DATA_W-1:0] reg_A,
  input  logic [DATA_W-1:0] reg_B,
  input  logic [DATA_W-1:0] smdr,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              alu_cf,
  input  logic              jump,
  output logic              cf_fb,
  output logic              stall,
  output logic [15:0]       mem_ir,
  output logic [DATA_W-1:0] reg_C,
  output logic              zf,
  output logic              nf,
  output logic              cf,
  output logic              dw,
  output logic [DATA_W-1:0] smdr1,
  output logic [DATA_W-1:0] reg_H
);

  localparam logic       EXEC     = 1'b1;
  localparam logic [4:0] OP_STORE = 5'b00011;
  localparam logic [4:0] OP_LDIH  = 5'b10000;
  localparam logic [4:0] OP_ADD   = 5'b01000;
  localparam logic [4:0] OP_ADDI  = 5'b01001;
  localparam logic [4:0] OP_ADDC  = 5'b10001;
  localparam logic [4:0] OP_SUB   = 5'b01010;
  localparam logic [4:0] OP_SUBI  = 5'b01011;
  localparam logic [4:0] OP_SUBC  = 5'b10010;
  localparam logic [4:0] OP_CMP   = 5'b01100;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} fsm_t;

  function automatic logic sets_flags(input logic [4:0] op);
    case (op)
      OP_LDIH, OP_ADD, OP_ADDI, OP_ADDC,
      OP_SUB, OP_SUBI, OP_SUBC, OP_CMP: sets_flags = 1'b1;
      default:                          sets_flags = 1'b0;
    endcase
  endfunction

  fsm_t                r_fsm, w_fsm_nxt;
  logic [2*DATA_W-1:0] r_acc, r_mcand;
  logic [DATA_W-1:0]   r_mplier;
  logic [CNT_W-1:0]    r_cnt;
  logic [15:0]         r_mem_ir;
  logic [DATA_W-1:0]   r_reg_c, r_smdr1;
  logic                r_zf, r_nf, r_cf, r_dw;

  logic [4:0]          w_opcode;
  logic                w_is_mul, w_last;
  logic [2*DATA_W-1:0] w_acc_nxt;
  logic [DATA_W-1:0]   w_prod_lo, w_prod_hi;

  assign w_opcode  = ex_ir[15:11];
  assign w_is_mul  = (w_opcode == MUL_OP);
  assign w_last    = (r_cnt == CNT_ONE);
  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : {(2*DATA_W){1'b0}});
  assign w_prod_lo = w_acc_nxt[DATA_W-1:0];
  assign w_prod_hi = w_acc_nxt[2*DATA_W-1:DATA_W];

  // FSM state register, frozen outside exec
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_fsm <= S_IDLE;
    end else if (state == EXEC) begin
      r_fsm <= w_fsm_nxt;
    end
  end

  // Next-state decode; a taken jump always aborts a running multiply
  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      S_IDLE: begin
        if (!jump && w_is_mul) w_fsm_nxt = S_BUSY;
        else                   w_fsm_nxt = S_IDLE;
      end
      S_BUSY: begin
        if (jump || w_last) w_fsm_nxt = S_IDLE;
        else                w_fsm_nxt = S_BUSY;
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

`ifdef MUL_HI_EN
  logic [DATA_W-1:0] r_reg_h;

  // Product high half, captured only when a multiply completes
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_reg_h <= {DATA_W{1'b0}};
    end else if (state == EXEC && r_fsm == S_BUSY && !jump && w_last) begin
      r_reg_h <= w_prod_hi;
    end
  end

  assign reg_H = r_reg_h;
`else
  assign reg_H = {DATA_W{1'b0}};
`endif

  // EX/MEM pipeline register and multiplier datapath
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_acc    <= {(2*DATA_W){1'b0}};
      r_mcand  <= {(2*DATA_W){1'b0}};
      r_mplier <= {DATA_W{1'b0}};
      r_cnt    <= {CNT_W{1'b0}};
      r_mem_ir <= 16'h0000;
      r_reg_c  <= {DATA_W{1'b0}};
      r_smdr1  <= {DATA_W{1'b0}};
      r_zf     <= 1'b0;
      r_nf     <= 1'b0;
      r_cf     <= 1'b0;
      r_dw     <= 1'b0;
    end else if (state == EXEC) begin
      case (r_fsm)
        S_IDLE: begin
          if (jump) begin
            r_mem_ir <= 16'h0000;
            r_dw     <= 1'b0;
          end else if (w_is_mul) begin
            r_acc    <= {(2*DATA_W){1'b0}};
            r_mcand  <= {{DATA_W{1'b0}}, reg_A};
            r_mplier <= reg_B;
            r_cnt    <= CNT_LOAD;
            r_mem_ir <= 16'h0000;
            r_dw     <= 1'b0;
          end else begin
            r_mem_ir <= ex_ir;
            r_reg_c  <= alu_res;
            r_dw     <= (w_opcode == OP_STORE);
            if (sets_flags(w_opcode)) begin
              r_zf <= (alu_res == {DATA_W{1'b0}});
              r_nf <= alu_res[DATA_W-1];
              r_cf <= alu_cf;
            end
            if (w_opcode == OP_STORE) r_smdr1 <= smdr;
          end
        end
        S_BUSY: begin
          r_dw <= 1'b0;
          if (jump) begin
            r_mem_ir <= 16'h0000;
          end else begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= {r_mcand[2*DATA_W-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[DATA_W-1:1]};
            r_cnt    <= r_cnt - CNT_ONE;
            // Final iteration retires the MUL with the wrapped product and overflow in cf
            if (w_last) begin
              r_mem_ir <= ex_ir;
              r_reg_c  <= w_prod_lo;
              r_zf     <= (w_prod_lo == {DATA_W{1'b0}});
              r_nf     <= w_prod_lo[DATA_W-1];
              r_cf     <= (w_prod_hi != {DATA_W{1'b0}});
            end else begin
              r_mem_ir <= 16'h0000;
            end
          end
        end
        default: begin
          r_mem_ir <= 16'h0000;
          r_dw     <= 1'b0;
        end
      endcase
    end
  end

  assign stall  = (r_fsm == S_BUSY);
  assign mem_ir = r_mem_ir;
  assign reg_C  = r_reg_c;
  assign smdr1  = r_smdr1;
  assign zf     = r_zf;
  assign nf     = r_nf;
  assign cf     = r_cf;
  assign cf_fb  = r_cf;
  assign dw     = r_dw;

endmodule

// File: tb/tb_ex_stage_mc.sv
// Scoreboard bench for ex_stage_mc: 16-bit instance with a retire monitor, plus an 8-bit instance.
module tb_ex_stage_mc;

  localparam logic [15:0] ADD_IR   = {5'b01000, 11'h021};
  localparam logic [15:0] STORE_IR = {5'b00011, 11'h042};
  localparam logic [15:0] SUB_IR   = {5'b01010, 11'h063};
  localparam logic [15:0] LOAD_IR  = {5'b00010, 11'h084};
  localparam logic [15:0] CMP_IR   = {5'b01100, 11'h0A5};
  localparam logic [15:0] MUL_IR   = {5'b11110, 11'h123};

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, state, jump, alu_cf;
  logic [15:0] ex_ir, reg_A, reg_B, smdr, alu_res;
  logic        cf_fb, stall, zf, nf, cf, dw;
  logic [15:0] mem_ir, reg_C, smdr1, reg_H;

  logic [15:0] ex_ir8, mem_ir8;
  logic [7:0]  a8, b8, smdr8, alu8, reg_C8, smdr1_8, reg_H8;
  logic        cf_fb8, stall8, zf8, nf8, cf8, dw8;

  ex_stage_mc #(.DATA_W(16)) u_dut (
    .clock(clock), .reset(reset), .state(state), .ex_ir(ex_ir),
    .reg_A(reg_A), .reg_B(reg_B), .smdr(smdr), .alu_res(alu_res),
    .alu_cf(alu_cf), .jump(jump), .cf_fb(cf_fb), .stall(stall),
    .mem_ir(mem_ir), .reg_C(reg_C), .zf(zf), .nf(nf), .cf(cf),
    .dw(dw), .smdr1(smdr1), .reg_H(reg_H)
  );

  ex_stage_mc #(.DATA_W(8)) u_dut8 (
    .clock(clock), .reset(reset), .state(state), .ex_ir(ex_ir8),
    .reg_A(a8), .reg_B(b8), .smdr(smdr8), .alu_res(alu8),
    .alu_cf(alu_cf), .jump(jump), .cf_fb(cf_fb8), .stall(stall8),
    .mem_ir(mem_ir8), .reg_C(reg_C8), .zf(zf8), .nf(nf8), .cf(cf8),
    .dw(dw8), .smdr1(smdr1_8), .reg_H(reg_H8)
  );

  typedef struct {
    logic [15:0] ir, c, s1, h;
    logic        z, n, f, w;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] exp_h = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Retire monitor: every exec edge that leaves a non-bubble in mem_ir consumes one expectation
  initial begin
    logic adv;
    exp_t e;
    forever begin
      @(posedge clock);
      adv = reset && (state == 1'b1);
      #2;
      if (adv && mem_ir !== 16'h0000) begin
        if (sb_q.size() == 0) begin
          check("unexpected_retire", {16'h0000, mem_ir}, 32'h0);
        end else begin
          e = sb_q.pop_front();
          check("mem_ir", {16'h0000, mem_ir}, {16'h0000, e.ir});
          check("reg_C", {16'h0000, reg_C}, {16'h0000, e.c});
          check("zf", {31'h0, zf}, {31'h0, e.z});
          check("nf", {31'h0, nf}, {31'h0, e.n});
          check("cf", {31'h0, cf}, {31'h0, e.f});
          check("cf_fb", {31'h0, cf_fb}, {31'h0, e.f});
          check("dw", {31'h0, dw}, {31'h0, e.w});
          check("smdr1", {16'h0000, smdr1}, {16'h0000, e.s1});
          check("reg_H", {16'h0000, reg_H}, {16'h0000, e.h});
        end
      end
    end
  end

  task automatic push(input logic [15:0] ir, input logic [15:0] c, input logic z,
                      input logic n, input logic f, input logic w, input logic [15:0] s1);
    exp_t e;
    e.ir = ir; e.c = c; e.z = z; e.n = n; e.f = f; e.w = w; e.s1 = s1; e.h = exp_h;
    sb_q.push_back(e);
  endtask

  // Single-cycle op: drive for one edge, then fall back to NOP
  task automatic issue(input logic [15:0] ir, input logic [15:0] res, input logic acf,
                       input logic [15:0] sm);
    ex_ir = ir; alu_res = res; alu_cf = acf; smdr = sm;
    @(negedge clock);
    ex_ir = 16'h0000;
  endtask

  // MUL with optional jump / freeze / reset injected after the given stall cycle
  task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input int abort_at,
                         input int freeze_at, input int rst_at, output int n_stall);
    int  frz;
    logic done;
    ex_ir = MUL_IR; reg_A = a; reg_B = b; jump = 1'b0; state = 1'b1;
    n_stall = 0; frz = 0; done = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clock);
      if (!stall) begin
        done = 1'b1;
        break;
      end
      n_stall++;
      check("bubble_mem_ir", {16'h0000, mem_ir}, 32'h0);
      if (frz > 0) begin
        frz--;
        if (frz == 0) state = 1'b1;
      end
      if (n_stall == abort_at) jump = 1'b1;
      if (n_stall == freeze_at) begin
        state = 1'b0;
        frz = 3;
      end
      if (n_stall == rst_at) reset = 1'b0;
    end
    if (!done) check("mul_timeout", {31'h0, stall}, 32'h0);
    ex_ir = 16'h0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ns;
    reset = 1'b0; state = 1'b1; jump = 1'b0; alu_cf = 1'b0;
    ex_ir = 16'h0000; reg_A = 16'h0000; reg_B = 16'h0000; smdr = 16'h0000; alu_res = 16'h0000;
    ex_ir8 = 16'h0000; a8 = 8'h00; b8 = 8'h00; smdr8 = 8'h00; alu8 = 8'h00;
    repeat (2) @(negedge clock);
    check("rst_mem_ir", {16'h0000, mem_ir}, 32'h0);
    check("rst_reg_C", {16'h0000, reg_C}, 32'h0);
    check("rst_flags", {29'h0, zf, nf, cf}, 32'h0);
    check("rst_dw_stall", {30'h0, dw, stall}, 32'h0);
    check("rst_smdr1", {16'h0000, smdr1}, 32'h0);
    check("rst_reg_H", {16'h0000, reg_H}, 32'h0);
    reset = 1'b1;

    push(ADD_IR, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
    issue(ADD_IR, 16'h0000, 1'b1, 16'h0000);
    push(STORE_IR, 16'h1234, 1'b1, 1'b0, 1'b1, 1'b1, 16'hBEEF);
    issue(STORE_IR, 16'h1234, 1'b0, 16'hBEEF);
    push(SUB_IR, 16'h8001, 1'b0, 1'b1, 1'b0, 1'b0, 16'hBEEF);
    issue(SUB_IR, 16'h8001, 1'b0, 16'h5555);
    push(LOAD_IR, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'hBEEF);
    issue(LOAD_IR, 16'h0000, 1'b1, 16'h0000);

    exp_h = 16'h0000;
    push(MUL_IR, 16'h03A8, 1'b0, 1'b0, 1'b0, 1'b0, 16'hBEEF);
    run_mul(16'h0012, 16'h0034, 0, 0, 0, ns);
    check("mul1_stall_cycles", ns, 16);

`ifdef MUL_HI_EN
    exp_h = 16'h0001;
`else
    exp_h = 16'h0000;
`endif
    push(MUL_IR, 16'hFFFE, 1'b0, 1'b1, 1'b1, 1'b0, 16'hBEEF);
    run_mul(16'hFFFF, 16'h0002, 0, 0, 0, ns);
    check("mul2_stall_cycles", ns, 16);

    run_mul(16'h0003, 16'h0005, 5, 0, 0, ns);
    check("abort_stall_cycles", ns, 5);
    check("abort_stall", {31'h0, stall}, 32'h0);
    check("abort_mem_ir", {16'h0000, mem_ir}, 32'h0);
    check("abort_flags", {29'h0, zf, nf, cf}, 32'h3);
    check("abort_reg_C", {16'h0000, reg_C}, 32'hFFFE);
    jump = 1'b0;

    push(ADD_IR, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0, 16'hBEEF);
    issue(ADD_IR, 16'h0005, 1'b0, 16'h0000);

    exp_h = 16'h0000;
    push(MUL_IR, 16'h03A8, 1'b0, 1'b0, 1'b0, 1'b0, 16'hBEEF);
    run_mul(16'h0012, 16'h0034, 0, 4, 0, ns);
    check("freeze_stall_cycles", ns, 19);

    run_mul(16'hFFFF, 16'hFFFF, 0, 0, 7, ns);
    check("midrst_stall_cycles", ns, 7);
    check("midrst_mem_ir", {16'h0000, mem_ir}, 32'h0);
    check("midrst_reg_C", {16'h0000, reg_C}, 32'h0);
    check("midrst_flags", {28'h0, zf, nf, cf, cf_fb}, 32'h0);
    check("midrst_dw_stall", {30'h0, dw, stall}, 32'h0);
    check("midrst_smdr1", {16'h0000, smdr1}, 32'h0);
    check("midrst_reg_H", {16'h0000, reg_H}, 32'h0);
    reset = 1'b1;
    exp_h = 16'h0000;

    push(CMP_IR, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    issue(CMP_IR, 16'h0000, 1'b0, 16'h0000);

    ex_ir8 = MUL_IR; a8 = 8'h10; b8 = 8'h10;
    ns = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clock);
      if (!stall8) break;
      ns++;
      check("mul8_bubble", {16'h0000, mem_ir8}, 32'h0);
    end
    check("mul8_stall_cycles", ns, 8);
    check("mul8_mem_ir", {16'h0000, mem_ir8}, {16'h0000, MUL_IR});
    check("mul8_reg_C", {24'h0, reg_C8}, 32'h0);
    check("mul8_flags", {29'h0, zf8, nf8, cf8}, 32'h5);
    ex_ir8 = 16'h0000;

    repeat (2) @(negedge clock);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
